cla_multiword_seq: RTL and testbench
====================================

Name: cla_multiword_seq

Overview:
- Word-serial sequencer that reuses one 16-bit carry-lookahead adder slice to add or subtract operands of 16*WORDS bits.
- Processes one 16-bit word per cycle, LSW first, and carries between words in a register.
- Sits between a requester (ALU/controller) and the CLA datapath. It trades latency for area when wide adds are infrequent.

Parameters:
- WORDS, 4, number of 16-bit words per operand (legal: 2..16); operand width = 16*WORDS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- sub  in  1  0: a+b+cin; 1: a-b (two's complement, cin ignored); sampled at accept.
- cin  in  1  carry into word 0 for add; sampled at accept.
- a  in  16*WORDS  operand A; sampled at accept.
- b  in  16*WORDS  operand B; sampled at accept.
- ready  out  1  high in IDLE and DONE; low in RUN.
- done  out  1  one-cycle pulse when results are valid.
- sum  out  16*WORDS  result; held until the next accept.
- cout  out  1  carry out of MSW (for sub: 1 = no borrow).
- ovf  out  1  signed overflow of the full-width operation.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, ready=1, done=0, sum=0, cout=0, ovf=0, word index=0, carry reg=0. Reset overrides start in the same cycle.
- Accept (start && ready):
  - Latch A.
  - Latch B' = sub ? ~b : b.
  - carry reg = sub ? 1 : cin.
  - index=0; clear sum; state=RUN.
- RUN, one word per cycle:
  - CLA inputs: A[idx], B'[idx], carry reg.
  - sum[idx] <= CLA sum; carry reg <= CLA cout; idx++.
  - On idx==WORDS-1:
    - cout <= CLA cout.
    - ovf <= (A msb ^ B' msb ^ sum msb) ^ CLA cout, i.e. carry into MSB xor carry out.
    - state=DONE.
- DONE: done=1 for exactly this cycle; ready=1.
  - start in DONE is accepted (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
  - In IDLE, outputs hold their last values.
- Latency: start accepted at edge T, done high in cycle T+WORDS+1. Throughput is one operation per WORDS+1 cycles.
- start while ready=0 is ignored; no queueing, no error flag.
- Operand inputs may change freely after accept; only the latched copies are used.
- Reset mid-RUN aborts: no done pulse, outputs return to reset values.
- Index counter width is clog2(WORDS); it never exceeds WORDS-1, so there is no wrap.
- Carry wraps 0xFFFF+1 across the word boundary correctly via the carry reg.

Optional Feature:
- Macro: CLA_MULTIWORD_ZERO_FLAG_EN.
- When defined:
  - Adds output zero (1 bit), reset 0.
  - A zero-accumulator is set to 1 at accept and ANDed with (CLA sum == 0) each RUN cycle.
  - zero is updated with cout/ovf at the last word and held thereafter.
- When undefined: no zero port, no accumulator logic.

Decomposition:
- Shared include cla_seq_defs.vh holds:
  - WORD_W=16.
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - clog2 helper function.
- One sub-module: the existing CLA_16bit instance as the per-word datapath. The sequencer uses its s and cout; p/g are left unconnected.
- Operand shift/select and FSM stay in this module; no other sub-modules.

Test Plan:
- WORDS=4, add, a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0, ovf=0; done exactly 5 cycles after accept edge.
- add, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, ovf=0 (ZERO_FLAG build: zero=1).
- sub, a=0x5, b=0x7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; sub, a=0x7, b=0x5 -> sum=0x2, cout=1.
- add, a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Protocol and reset:
  - start pulsed during RUN is ignored (single done, result of first op).
  - rst asserted at word 2 of RUN -> next cycle ready=1, sum=0, no done pulse.
- Back-to-back: start held high through DONE with new operands -> second op accepted in DONE cycle, second done 5 cycles later, first result visible during first done cycle.

Source files
------------

// File: rtl/cla_multiword_seq_pkg.sv
// Shared definitions for the word-serial CLA sequencer: word width, FSM
// state encoding and a constant clog2 helper for sizing the word index.
package cla_multiword_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Smallest r with 2**r >= value; callers guarantee value >= 2.
    function automatic int seq_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_multiword_seq_cla16.sv
// 16-bit carry-lookahead adder: 4-bit groups, second-level lookahead across groups.
// Purely combinational; no backpressure.
// Group propagate/generate outputs allow cascading into a wider lookahead tree.
module cla_multiword_seq_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        p,
    output logic        g
);

    logic [15:0] bit_g;
    logic [15:0] bit_p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  c;
    logic        ripple;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 4; k++) begin
            grp_p[k] = &bit_p[4*k +: 4];
            grp_g[k] = bit_g[4*k+3]
                     | (bit_p[4*k+3] & bit_g[4*k+2])
                     | ((&bit_p[4*k+2 +: 2]) & bit_g[4*k+1])
                     | ((&bit_p[4*k+1 +: 3]) & bit_g[4*k]);
        end
    end

    // Group carries computed directly from cin so no carry depends on another.
    assign c = {
        grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]) | ((&grp_p) & cin),
        grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
            | (grp_p[2] & grp_p[1] & grp_p[0] & cin),
        grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin),
        grp_g[0] | (grp_p[0] & cin),
        cin
    };

    always_comb begin
        s      = '0;
        ripple = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ripple = c[k];
            for (int j = 0; j < 4; j++) begin
                s[4*k+j] = bit_p[4*k+j] ^ ripple;
                ripple   = bit_g[4*k+j] | (bit_p[4*k+j] & ripple);
            end
        end
    end

    assign cout = c[4];
    assign p    = &grp_p;
    assign g    = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

endmodule

// File: rtl/cla_multiword_seq.sv
// Word-serial add/sub of 16*WORDS-bit operands through one 16-bit CLA, LSW first.
// Latency: accept edge T -> done pulse in the cycle after edge T+WORDS; back-to-back every WORDS+1 cycles.
// Backpressure: ready low while RUN, start ignored then. Optional zero output under CLA_MULTIWORD_ZERO_FLAG_EN.
module cla_multiword_seq
    import cla_multiword_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic                    cin,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    output logic                    ready,
    output logic                    done,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf
`ifdef CLA_MULTIWORD_ZERO_FLAG_EN
    ,
    output logic                    zero
`endif
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = seq_clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t         state;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;

    logic [WORD_W-1:0]  a_word;
    logic [WORD_W-1:0]  b_word;
    logic [WORD_W-1:0]  cla_s;
    logic               cla_cout;
    logic               cla_p_unused;
    logic               cla_g_unused;
    logic               ovf_next;

    assign a_word = a_q[WORD_W*int'(idx) +: WORD_W];
    assign b_word = b_q[WORD_W*int'(idx) +: WORD_W];

    // Carry into the MSB is a^b^s at that bit; overflow when it differs from carry out.
    assign ovf_next = a_word[WORD_W-1] ^ b_word[WORD_W-1] ^ cla_s[WORD_W-1] ^ cla_cout;

    cla_multiword_seq_cla16 u_cla (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .s    (cla_s),
        .cout (cla_cout),
        .p    (cla_p_unused),
        .g    (cla_g_unused)
    );

`ifdef CLA_MULTIWORD_ZERO_FLAG_EN
    logic zero_acc;
    logic word_zero;

    assign word_zero = (cla_s == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_acc <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        zero_acc <= 1'b1;
                    end
                end
                RUN: begin
                    zero_acc <= zero_acc & word_zero;
                    if (idx == LAST_IDX) begin
                        zero <= zero_acc & word_zero;
                    end
                end
                default: zero_acc <= 1'b0;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        idx     <= '0;
                        sum     <= '0;
                        ready   <= 1'b0;
                        state   <= RUN;
                    end else begin
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    sum[WORD_W*int'(idx) +: WORD_W] <= cla_s;
                    carry_q <= cla_cout;
                    if (idx == LAST_IDX) begin
                        cout  <= cla_cout;
                        ovf   <= ovf_next;
                        idx   <= '0;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Bench for cla_multiword_seq (WORDS=4): directed corner cases plus random
// add/sub against a full-width arithmetic reference model.
module tb_cla_multiword_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef CLA_MULTIWORD_ZERO_FLAG_EN
    logic         zero;
`endif

    int errors = 0;
    int checks = 0;

    cla_multiword_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
`ifdef CLA_MULTIWORD_ZERO_FLAG_EN
        ,
        .zero  (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Reference: whole-operand arithmetic, borrow/overflow from operand signs.
    function automatic void model(input logic s, input logic c, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] r,
                                  output logic co, output logic ov);
        logic [W:0] t;
        if (s) begin
            t  = {1'b0, x} - {1'b0, y};
            r  = t[W-1:0];
            co = (x >= y);
            ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            t  = {1'b0, x} + {1'b0, y} + (W+1)'(c);
            r  = t[W-1:0];
            co = t[W];
            ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
    endfunction

    // Waits for done starting just after an accept edge; returns edges elapsed.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] er, input logic eco,
                                input logic eov);
        check({tag, " sum"}, sum, er);
        check({tag, " cout"}, W'(cout), W'(eco));
        check({tag, " ovf"}, W'(ovf), W'(eov));
`ifdef CLA_MULTIWORD_ZERO_FLAG_EN
        check({tag, " zero"}, W'(zero), W'(er == '0));
`endif
    endtask

    // Called at a negedge with the DUT ready; returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic s, input logic c,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic         eco;
        logic         eov;
        int           lat;
        model(s, c, x, y, er, eco, eov);
        start = 1'b1; sub = s; cin = c; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; a = rand64(); b = rand64(); sub = 1'($urandom); cin = 1'($urandom);
        wait_done(lat);
        check({tag, " latency"}, W'(lat), W'(WORDS));
        check_result(tag, er, eco, eov);
        @(negedge clk);
        check({tag, " done pulse width"}, W'(done), '0);
        check({tag, " ready after"}, W'(ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] x, y, x2, y2, er, er2, got;
        logic         s, c, s2, eco, eov, eco2, eov2;
        int           lat, dcount;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", W'(ready), W'(1));
        check("reset done", W'(done), '0);
        check("reset sum", sum, '0);
        check("reset cout", W'(cout), '0);
        check("reset ovf", W'(ovf), '0);
`ifdef CLA_MULTIWORD_ZERO_FLAG_EN
        check("reset zero", W'(zero), '0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op("word carry", 1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
        repeat (3) @(negedge clk);
        check("idle hold sum", sum, 64'h0000_0000_0001_0000);
        run_op("full wrap", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        run_op("sub 5-7", 1'b1, 1'b1, 64'h5, 64'h7);
        run_op("sub 7-5", 1'b1, 1'b0, 64'h7, 64'h5);
        run_op("pos ovf", 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        run_op("cin only", 1'b0, 1'b1, 64'h0, 64'h0);

        for (int i = 0; i < 24; i++) begin
            x = rand64();
            y = rand64();
            s = 1'($urandom);
            c = 1'($urandom);
            if ($urandom_range(0, 3) == 0) y = ~x;
            run_op($sformatf("random %0d", i), s, c, x, y);
        end

        // start during RUN must be dropped
        x = rand64(); y = rand64(); x2 = rand64(); y2 = rand64();
        model(1'b0, 1'b1, x, y, er, eco, eov);
        start = 1'b1; sub = 1'b0; cin = 1'b1; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy ready low", W'(ready), '0);
        start = 1'b1; sub = 1'b1; a = x2; b = y2;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        got = '0;
        repeat (WORDS + 4) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcount++;
                got = sum;
            end
        end
        check("busy done count", W'(dcount), W'(1));
        check("busy result", got, er);

        // leave cout/ovf at 1 so the abort visibly clears them
        run_op("neg ovf", 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        start = 1'b1; sub = 1'b0; cin = 1'b0; a = rand64(); b = rand64();
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort ready", W'(ready), W'(1));
        check("abort sum", sum, '0);
        check("abort done", W'(done), '0);
        check("abort cout", W'(cout), '0);
        check("abort ovf", W'(ovf), '0);
        rst = 1'b0;
        dcount = 0;
        repeat (WORDS + 3) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("abort no done", W'(dcount), '0);

        // back-to-back: start held through DONE
        x = rand64(); y = rand64(); s = 1'($urandom); c = 1'($urandom);
        x2 = rand64(); y2 = rand64(); s2 = 1'($urandom);
        model(s, c, x, y, er, eco, eov);
        model(s2, 1'b0, x2, y2, er2, eco2, eov2);
        start = 1'b1; sub = s; cin = c; a = x; b = y;
        @(posedge clk);
        #1;
        sub = s2; cin = 1'b0; a = x2; b = y2;
        wait_done(lat);
        check("b2b first latency", W'(lat), W'(WORDS));
        check_result("b2b first", er, eco, eov);
        @(posedge clk);
        #1 start = 1'b0; a = rand64(); b = rand64();
        wait_done(lat);
        check("b2b done spacing", W'(lat + 1), W'(WORDS + 1));
        check_result("b2b second", er2, eco2, eov2);
        @(negedge clk);
        check("b2b pulse width", W'(done), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
